// File: rtl/crop_pkg.sv
// crop_pkg: shared raster geometry defaults, coordinate width and window-bounds type.
package crop_pkg;
    localparam int COORD_W = 16;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef struct packed {
        logic [COORD_W-1:0] xs;
        logic [COORD_W-1:0] xe;
        logic [COORD_W-1:0] ys;
        logic [COORD_W-1:0] ye;
    } win_t;

    function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v, input logic [COORD_W-1:0] max);
        return v > max ? max : v;
    endfunction
endpackage

// File: rtl/crop_window_if.sv
// crop_window_if: pixel stream in, cropped pixel stream out, plus per-frame crop bounds.
interface crop_window_if #(parameter int DATA_W = 10);
    import crop_pkg::*;
    logic               iDVAL;
    logic [DATA_W-1:0]  iDATA;
    logic [COORD_W-1:0] iXSTART, iXEND, iYSTART, iYEND;
    logic               oDVAL;
    logic [DATA_W-1:0]  oDATA;
    logic [COORD_W-1:0] oX, oY;
    logic               oFRAME_DONE;
    logic               oBAD_WIN;

    modport master (
        output iDVAL, iDATA, iXSTART, iXEND, iYSTART, iYEND,
        input  oDVAL, oDATA, oX, oY, oFRAME_DONE, oBAD_WIN
    );
    modport slave (
        input  iDVAL, iDATA, iXSTART, iXEND, iYSTART, iYEND,
        output oDVAL, oDATA, oX, oY, oFRAME_DONE, oBAD_WIN
    );
endinterface

// File: rtl/raster_counter.sv
// raster_counter: X/Y position of the pixel currently offered, advancing on each accepted pixel.
module raster_counter
    import crop_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               first_o,
    output logic               last_o
);
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic x_wrap, y_wrap;

    always_comb begin
        x_wrap = x_q == COORD_W'(H_ACTIVE - 1);
        y_wrap = y_q == COORD_W'(V_ACTIVE - 1);
        x_d = !en_i ? x_q : x_wrap ? '0 : x_q + COORD_W'(1);
        y_d = !(en_i && x_wrap) ? y_q : y_wrap ? '0 : y_q + COORD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
    assign first_o = x_q == '0 && y_q == '0;
    assign last_o = x_wrap && y_wrap;
endmodule

// File: rtl/crop_window.sv
// crop_window: crops a raster pixel stream to a window latched at the start of each frame,
// emitting window-relative coordinates with one cycle of latency.
module crop_window
    import crop_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int DATA_W   = 10
) (
    input logic          iCLK,
    input logic          iRST,
    crop_window_if.slave bus
);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);
    localparam win_t FULL_WIN = '{xs: '0, xe: X_MAX, ys: '0, ye: Y_MAX};

    logic [COORD_W-1:0] x, y;
    logic first, last, latch, in_win, bad_new;
    win_t win_cl, win_new, win_cur, win_q, win_d;
    logic dval_q, dval_d, done_q, done_d, bad_q, bad_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;

    raster_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_cnt (
        .clk(iCLK), .rst(iRST), .en_i(bus.iDVAL),
        .x_o(x), .y_o(y), .first_o(first), .last_o(last)
    );

    // The (0,0) pixel is judged against the window being latched on the same cycle.
    always_comb begin
        win_cl = '{xs: bus.iXSTART, xe: clamp(bus.iXEND, X_MAX), ys: bus.iYSTART, ye: clamp(bus.iYEND, Y_MAX)};
        bad_new = win_cl.xs > win_cl.xe || win_cl.ys > win_cl.ye;
        win_new = bad_new ? FULL_WIN : win_cl;
        latch = bus.iDVAL && first;
        win_cur = latch ? win_new : win_q;
        in_win = bus.iDVAL && x >= win_cur.xs && x <= win_cur.xe && y >= win_cur.ys && y <= win_cur.ye;
        win_d = win_cur;
        bad_d = latch ? bad_new : bad_q;
        dval_d = in_win;
        done_d = bus.iDVAL && last;
        data_d = in_win ? bus.iDATA : data_q;
        ox_d = in_win ? x - win_cur.xs : ox_q;
        oy_d = in_win ? y - win_cur.ys : oy_q;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            win_q <= '0;
            bad_q <= 1'b0;
            dval_q <= 1'b0;
            done_q <= 1'b0;
            data_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            win_q <= win_d;
            bad_q <= bad_d;
            dval_q <= dval_d;
            done_q <= done_d;
            data_q <= data_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

    assign bus.oDVAL = dval_q;
    assign bus.oDATA = data_q;
    assign bus.oX = ox_q;
    assign bus.oY = oy_q;
    assign bus.oFRAME_DONE = done_q;
    assign bus.oBAD_WIN = bad_q;
endmodule

// File: tb/tb_crop_window.sv
// tb_crop_window: randomized stream against a frame-level reference model on a reduced 16x12 raster.
module tb_crop_window;
    localparam int H = 16, V = 12, DW = 10, NPIX = H * V;

    logic clk = 1'b0, rst;
    always #5 clk = ~clk;

    crop_window_if #(.DATA_W(DW)) bus ();
    crop_window #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW)) dut (.iCLK(clk), .iRST(rst), .bus(bus));

    int vectors, miscompares;
    int n, got_pix;
    int wxs, wxe, wys, wye;
    logic e_dval, e_done, e_bad;
    logic [DW-1:0] e_data;
    int e_x, e_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic set_win(input int xs, input int xe, input int ys, input int ye);
        bus.iXSTART = 16'(xs);
        bus.iXEND = 16'(xe);
        bus.iYSTART = 16'(ys);
        bus.iYEND = 16'(ye);
    endtask

    // n is the index of the next pixel within the frame; the window is decided when n==0 is accepted.
    task automatic step(input bit v, input bit r);
        int x, y, xe, ye;
        rst = r;
        bus.iDVAL = v;
        bus.iDATA = DW'($urandom);
        if (r) begin
            n = 0; got_pix = 0;
            e_dval = 0; e_data = '0; e_x = 0; e_y = 0; e_done = 0; e_bad = 0;
        end else begin
            e_dval = 0;
            e_done = 0;
            if (v) begin
                x = n % H;
                y = n / H;
                if (n == 0) begin
                    xe = int'(bus.iXEND) > H - 1 ? H - 1 : int'(bus.iXEND);
                    ye = int'(bus.iYEND) > V - 1 ? V - 1 : int'(bus.iYEND);
                    e_bad = int'(bus.iXSTART) > xe || int'(bus.iYSTART) > ye;
                    wxs = e_bad ? 0 : int'(bus.iXSTART);
                    wxe = e_bad ? H - 1 : xe;
                    wys = e_bad ? 0 : int'(bus.iYSTART);
                    wye = e_bad ? V - 1 : ye;
                end
                if (x >= wxs && x <= wxe && y >= wys && y <= wye) begin
                    e_dval = 1;
                    e_data = bus.iDATA;
                    e_x = x - wxs;
                    e_y = y - wys;
                end
                e_done = n == NPIX - 1;
                n = (n + 1) % NPIX;
            end
        end
        @(posedge clk);
        #1;
        check("oDVAL", 32'(bus.oDVAL), 32'(e_dval));
        check("oDATA", 32'(bus.oDATA), 32'(e_data));
        check("oX", 32'(bus.oX), 32'(e_x));
        check("oY", 32'(bus.oY), 32'(e_y));
        check("oFRAME_DONE", 32'(bus.oFRAME_DONE), 32'(e_done));
        check("oBAD_WIN", 32'(bus.oBAD_WIN), 32'(e_bad));
        if (!r) begin
            if (bus.oDVAL) got_pix++;
            if (e_done) begin
                check("frame_pixels", 32'(got_pix), 32'((wxe - wxs + 1) * (wye - wys + 1)));
                got_pix = 0;
            end
        end
    endtask

    task automatic run_px(input int cnt, input int duty);
        int acc;
        bit v;
        acc = 0;
        while (acc < cnt) begin
            v = $urandom_range(0, 99) < duty;
            step(v, 0);
            if (v) acc++;
        end
    endtask

    initial begin
        int k;
        vectors = 0; miscompares = 0; n = 0; got_pix = 0;
        wxs = 0; wxe = H - 1; wys = 0; wye = V - 1;
        rst = 1'b1; bus.iDVAL = 1'b0; bus.iDATA = '0;
        set_win(0, 0, 0, 0);
        step(1, 1);
        step(0, 1);
        set_win(3, 10, 2, 7);    run_px(NPIX, 100);
        set_win(12, 8, 0, 11);   run_px(NPIX, 100);
        set_win(10, 1000, 9, 900); run_px(NPIX, 100);
        set_win(5, 5, 4, 4);     run_px(NPIX, 60);
        set_win(2, 12, 1, 10);   run_px(5 * H, 100);
        bus.iXEND = 16'd6;       run_px(NPIX - 5 * H, 100);
        run_px(NPIX, 100);
        for (int f = 0; f < 20; f++) begin
            set_win($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 14), $urandom_range(0, 14));
            k = $urandom_range(1, NPIX - 1);
            run_px(k, 30);
            set_win($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 14), $urandom_range(0, 14));
            run_px(NPIX - k, 30);
        end
        set_win(4, 9, 3, 8);
        run_px(6 * H + 8, 70);
        step(1, 1);
        set_win(0, 5, 0, 3);
        run_px(NPIX, 100);
        repeat (3) step(0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/crop_window.md
CROP_WINDOW -- requirements
Module: crop_window

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter DATA_W, default 10, pixel width.
REQ-004 iCLK  input  1  single clock; all logic on its rising edge.
REQ-005 iRST  input  1  reset, synchronous and active-high.
REQ-006 iDVAL  input  1  input pixel valid; raster order, no other sync signals.
REQ-007 iDATA  input  DATA_W  input pixel.
REQ-008 iXSTART, iXEND  input  16 each  inclusive horizontal crop bounds; iXEND is driven by the upstream X-extent detector.
REQ-009 iYSTART, iYEND  input  16 each  inclusive vertical crop bounds.
REQ-010 oDVAL  output  1  output pixel valid; high only for in-window pixels.
REQ-011 oDATA  output  DATA_W  cropped pixel.
REQ-012 oX, oY  output  16 each  pixel coordinate relative to the window origin.
REQ-013 oFRAME_DONE  output  1  one-cycle pulse marking the last input pixel of a frame.
REQ-014 oBAD_WIN  output  1  high for a whole frame whose latched window was invalid.

Function
REQ-015 Raster counters X (0..H_ACTIVE-1) and Y (0..V_ACTIVE-1) SHALL advance only on cycles with iDVAL=1.
- X wraps to 0 after H_ACTIVE-1 and increments Y.
- Y wraps to 0 after V_ACTIVE-1.
REQ-016 Cycles with iDVAL=0 SHALL hold both counters, drive oDVAL=0 and oFRAME_DONE=0, and hold oDATA/oX/oY.
REQ-017 On the cycle that accepts pixel (X=0,Y=0), bounds SHALL be copied into shadow registers; shadows stay constant for the rest of the frame.
- Bound input changes mid-frame have no effect until the next frame.
REQ-018 Shadow xend SHALL be clamped to H_ACTIVE-1 and shadow yend to V_ACTIVE-1 when larger.
REQ-019 A window is invalid if xstart>xend or ystart>yend after clamping.
- An invalid window SHALL be replaced by the full frame (0..H_ACTIVE-1, 0..V_ACTIVE-1).
- oBAD_WIN=1 from the first output of that frame until the next frame's latch.
REQ-020 A pixel is in-window when xs<=X<=xe and ys<=Y<=ye, all inclusive.
REQ-021 Latency SHALL be exactly one cycle for in-window pixels: oDVAL=1, oDATA=iDATA, oX=X-xs, oY=Y-ys.
REQ-022 Out-of-window pixels SHALL give oDVAL=0 and leave oDATA/oX/oY unchanged.
REQ-023 oFRAME_DONE SHALL pulse one cycle after accepting pixel (H_ACTIVE-1, V_ACTIVE-1), whether or not that pixel is in-window.
REQ-024 The (0,0) pixel SHALL be tested against the newly latched window, not the previous frame's window.
REQ-025 A window of width 1 and height 1 SHALL emit exactly one pixel per frame.
REQ-026 Coordinate subtraction SHALL be 16-bit unsigned; by construction it never underflows.

Reset
REQ-027 When iRST=1 at a clock edge, the following SHALL be cleared to 0:
- X, Y, and all shadows;
- oDVAL, oDATA, oX, oY, oFRAME_DONE, oBAD_WIN.
REQ-028 Reset SHALL win over a simultaneous iDVAL=1.
REQ-029 After a mid-frame reset, the next accepted pixel SHALL be treated as (0,0) of a new frame, including a new bounds latch.

Structure
REQ-030 A shared package crop_pkg SHALL hold:
- H_ACTIVE and V_ACTIVE defaults;
- coordinate width 16;
- a window-bounds struct {xs, xe, ys, ye}.
REQ-031 The X/Y counting SHALL be one sub-module, raster_counter.
- Outputs: X, Y, first-pixel flag, last-pixel flag.
- Reused by other stream stages.
REQ-032 Window check, clamp and output registers SHALL live in crop_window.

Verification
REQ-033 Window 161..479 x 121..189, continuous iDVAL:
- exactly 319*69=22011 oDVAL pulses per frame;
- first output oX=0,oY=0 with pixel (161,121); last output oX=318,oY=68.
REQ-034 iXSTART=500, iXEND=400:
- oBAD_WIN=1 for the frame;
- 307200 oDVAL pulses;
- output coordinates equal input coordinates.
REQ-035 iXEND=1000, iYEND=900, starts 600/470:
- clamped to 600..639 x 470..479;
- 400 outputs; last oX=39,oY=9.
REQ-036 Change iXEND from 300 to 200 at line 50 of a frame:
- current frame still uses 300;
- next frame uses 200.
REQ-037 Random iDVAL gaps at 30% duty:
- output pixel sequence identical to the gapless run;
- oFRAME_DONE exactly once per 307200 accepted pixels.
REQ-038 Assert iRST at pixel (320,240) for 1 cycle:
- all outputs 0 next cycle;
- the next accepted pixel latches bounds and, if in-window, emits oX=0,oY=0 when xs=ys=0.
